// File: rtl/forward_hazard_control.sv
// EX-stage operand-forwarding select and load-use stall generator for the 5-stage core.
// Keeps a shadow scoreboard of the EX/MEM/WB destination registers beside the ID/EX buffer.
module forward_hazard_control #(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid_ip,
    input  logic [REG_AW-1:0] id_rs1_addr_ip,
    input  logic [REG_AW-1:0] id_rs2_addr_ip,
    input  logic              id_rs1_used_ip,
    input  logic              id_rs2_used_ip,
    input  logic [REG_AW-1:0] id_rd_addr_ip,
    input  logic              id_rd_we_ip,
    input  logic              id_is_load_ip,
    input  logic              flush_en_ip,
    output logic [1:0]        fa_mux_op,
    output logic [1:0]        fb_mux_op,
    output logic              stall_op,
    output logic [CNT_W-1:0]  stall_count_op,
    output logic [CNT_W-1:0]  fwd_count_op
);

    localparam logic [1:0] NO_FORWARD       = 2'b00;
    localparam logic [1:0] EX_RESULT_SELECT = 2'b01;
    localparam logic [1:0] WB_RESULT_SELECT = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } slot_t;

    slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]        fa_q, fa_d, fb_q, fb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
    logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2, ld_hit1, ld_hit2;
    logic              stall;

    function automatic logic match(input slot_t s, input logic [REG_AW-1:0] a);
        return s.valid && s.we && (s.rd != '0) && (s.rd == a);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // The younger producer in EX wins over MEM; a load in EX cannot forward yet.
    function automatic logic [1:0] select(input logic used, input logic ex_hit,
                                          input logic ex_load, input logic mem_hit);
        if (!used)                return NO_FORWARD;
        else if (ex_hit && !ex_load) return EX_RESULT_SELECT;
        else if (mem_hit)         return WB_RESULT_SELECT;
        else                      return NO_FORWARD;
    endfunction

    always_comb begin
        ex_hit1  = match(ex_q, id_rs1_addr_ip);
        ex_hit2  = match(ex_q, id_rs2_addr_ip);
        mem_hit1 = match(mem_q, id_rs1_addr_ip);
        mem_hit2 = match(mem_q, id_rs2_addr_ip);
        ld_hit1  = ex_hit1 && ex_q.is_load;
        ld_hit2  = ex_hit2 && ex_q.is_load;
        stall    = reset && id_valid_ip && !flush_en_ip &&
                   ((id_rs1_used_ip && ld_hit1) || (id_rs2_used_ip && ld_hit2));

        mem_d       = ex_q;
        wb_d        = mem_q;
        ex_d        = '0;
        fa_d        = NO_FORWARD;
        fb_d        = NO_FORWARD;
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = ((fa_q != NO_FORWARD) || (fb_q != NO_FORWARD)) ? sat_inc(fwd_cnt_q) : fwd_cnt_q;

        if (flush_en_ip) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d        = '0;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ex_d.valid   = id_valid_ip;
            ex_d.rd      = id_rd_addr_ip;
            ex_d.we      = id_rd_we_ip && id_valid_ip;
            ex_d.is_load = id_is_load_ip;
            if (id_valid_ip) begin
                fa_d = select(id_rs1_used_ip, ex_hit1, ex_q.is_load, mem_hit1);
                fb_d = select(id_rs2_used_ip, ex_hit2, ex_q.is_load, mem_hit2);
            end
        end
    end

    // ---- ID -> EX boundary: scoreboard shift and registered selects ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fa_q        <= NO_FORWARD;
            fb_q        <= NO_FORWARD;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    // The WB slot is tracked but never forwarded from: the register file is write-before-read.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign fa_mux_op      = fa_q;
    assign fb_mux_op      = fb_q;
    assign stall_op       = stall;
    assign stall_count_op = stall_cnt_q;
    assign fwd_count_op   = fwd_cnt_q;

endmodule
